// File: rtl/vga_pixel_feeder.sv
// Pixmap write-side feeder for the 40x30 VGA image block: buffers CPU pixels in a small
// FIFO and replays them as add_input strobes, tracking the display cursor and clears.
module vga_pixel_feeder #(
  parameter int PW      = 40,
  parameter int PH      = 30,
  parameter int DEPTH   = 4,
  parameter int HOLD    = 2,
  parameter int GAP     = 2,
  parameter int CLR_CYC = 2
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [11:0] in_rgb,
  output logic        in_ready,
  input  logic        clr_req,
  output logic        add_input,
  output logic [11:0] rgb_code,
  output logic        disp_reset,
  output logic [10:0] cursor,
  output logic        frame_done,
  output logic        busy
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int MAXC  = (MAXHG > CLR_CYC) ? MAXHG : CLR_CYC;
  localparam int CW    = $clog2(MAXC) + 1;

  localparam logic [10:0]   LAST   = 11'(PW * PH - 1);
  localparam logic [CW-1:0] HOLD_L = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_L  = CW'(GAP - 1);
  localparam logic [CW-1:0] CLR_L  = CW'(CLR_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          clr_pend;

  logic [11:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  logic empty, full, push, pop, go_clear;
  logic hold_end, gap_end, clr_end;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full && !clr_pend && (state != ST_CLEAR);
  assign push     = in_valid && in_ready;

  assign hold_end = (state == ST_DRIVE) && (cnt == HOLD_L);
  assign gap_end  = (state == ST_GAP)   && (cnt == GAP_L);
  assign clr_end  = (state == ST_CLEAR) && (cnt == CLR_L);

  // A pending clear wins over queued pixels at both decision points.
  assign go_clear = clr_pend && ((state == ST_IDLE) || gap_end);
  assign pop      = !go_clear && !empty && ((state == ST_IDLE) || gap_end);

  assign busy = (state != ST_IDLE) || !empty || clr_pend;

  always_ff @(posedge clk_50) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_rgb;
  end

  always_ff @(posedge clk_50) begin
    if (reset || go_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      clr_pend   <= 1'b0;
      add_input  <= 1'b0;
      rgb_code   <= '0;
      disp_reset <= 1'b0;
      cursor     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      // A request arriving on the clear-entry edge is kept so it is not lost.
      if (clr_req)       clr_pend <= 1'b1;
      else if (go_clear) clr_pend <= 1'b0;

      if (go_clear) begin
        state      <= ST_CLEAR;
        cnt        <= '0;
        disp_reset <= 1'b1;
        cursor     <= '0;
      end else if (pop) begin
        state     <= ST_DRIVE;
        cnt       <= '0;
        add_input <= 1'b1;
        rgb_code  <= mem[rd_ptr[AW-1:0]];
      end else begin
        case (state)
          ST_DRIVE: begin
            if (hold_end) begin
              add_input <= 1'b0;
              state     <= ST_GAP;
              cnt       <= '0;
              if (cursor == LAST) begin
                cursor     <= '0;
                frame_done <= 1'b1;
              end else begin
                cursor <= cursor + 11'd1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_GAP: begin
            if (gap_end) state <= ST_IDLE;
            else         cnt   <= cnt + CW'(1);
          end
          ST_CLEAR: begin
            if (clr_end) begin
              disp_reset <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
